// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// RV32 IF stage: owns the PC, keeps one imem request in flight and presents
// the {pc, instr, invalid, misaligned} bundle to IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stop,
  input  logic                 flush,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic [31:0]          if_pc,
  output logic [31:0]          if_instr,
  output logic                 if_invalid,
  output logic                 if_misaligned
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DISCARD, S_FAULT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_buf, r_if_pc, r_if_instr;
  logic        r_if_invalid, r_if_misaligned, r_boot, r_fault_done;
  logic [31:0] w_pc_nxt, w_buf_nxt, w_if_pc_nxt, w_if_instr_nxt;
  logic        w_if_invalid_nxt, w_if_misaligned_nxt, w_fault_done_nxt;
  logic        w_req, w_ack, w_redir_mis, w_discard_mis;
  logic [31:0] w_pc_inc, w_discard_pc;

  // r_boot masks the first cycle after reset: no request, stale acks ignored
  assign w_req         = (r_state == S_FETCH) && !r_boot;
  assign w_ack         = imem.imem_ack && !r_boot;
  assign w_redir_mis   = |redirect_pc[1:0];
  assign w_pc_inc      = r_pc + 32'd4;
  assign w_discard_pc  = redirect_valid ? redirect_pc : r_pc;
  assign w_discard_mis = |w_discard_pc[1:0];

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;
  assign if_pc          = r_if_pc;
  assign if_instr       = r_if_instr;
  assign if_invalid     = r_if_invalid;
  assign if_misaligned  = r_if_misaligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_FETCH;
      r_pc            <= RESET_PC;
      r_buf           <= 32'd0;
      r_boot          <= 1'b1;
      r_fault_done    <= 1'b0;
      r_if_pc         <= 32'd0;
      r_if_instr      <= NOP_INSTR;
      r_if_invalid    <= 1'b1;
      r_if_misaligned <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_pc            <= w_pc_nxt;
      r_buf           <= w_buf_nxt;
      r_boot          <= 1'b0;
      r_fault_done    <= w_fault_done_nxt;
      r_if_pc         <= w_if_pc_nxt;
      r_if_instr      <= w_if_instr_nxt;
      r_if_invalid    <= w_if_invalid_nxt;
      r_if_misaligned <= w_if_misaligned_nxt;
    end
  end

  // A redirect with a request still in flight must first swallow the stale ack
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_FETCH: begin
        if (redirect_valid)
          w_state_nxt = (w_req && !w_ack) ? S_DISCARD : (w_redir_mis ? S_FAULT : S_FETCH);
        else if (w_req && w_ack && stop)
          w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (redirect_valid)
          w_state_nxt = w_redir_mis ? S_FAULT : S_FETCH;
        else if (!stop)
          w_state_nxt = S_FETCH;
      end
      S_DISCARD: begin
        if (w_ack)
          w_state_nxt = w_discard_mis ? S_FAULT : S_FETCH;
      end
      S_FAULT: begin
        if (redirect_valid)
          w_state_nxt = w_redir_mis ? S_FAULT : S_FETCH;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_nxt            = r_pc;
    w_buf_nxt           = r_buf;
    w_fault_done_nxt    = r_fault_done;
    w_if_pc_nxt         = r_if_pc;
    w_if_instr_nxt      = r_if_instr;
    w_if_invalid_nxt    = r_if_invalid;
    w_if_misaligned_nxt = r_if_misaligned;
    if (redirect_valid) begin
      w_pc_nxt            = redirect_pc;
      w_fault_done_nxt    = 1'b0;
      w_if_invalid_nxt    = 1'b1;
      w_if_misaligned_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (w_req && w_ack) begin
            if (!stop) begin
              w_if_instr_nxt      = imem.imem_rdata;
              w_if_pc_nxt         = r_pc;
              w_if_invalid_nxt    = flush;
              w_if_misaligned_nxt = 1'b0;
              w_pc_nxt            = w_pc_inc;
            end else begin
              w_buf_nxt = imem.imem_rdata;
            end
          end else if (!stop) begin
            w_if_invalid_nxt    = 1'b1;
            w_if_misaligned_nxt = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stop) begin
            w_if_instr_nxt      = r_buf;
            w_if_pc_nxt         = r_pc;
            w_if_invalid_nxt    = flush;
            w_if_misaligned_nxt = 1'b0;
            w_pc_nxt            = w_pc_inc;
          end
        end
        S_DISCARD: begin
          if (!stop) begin
            w_if_invalid_nxt    = 1'b1;
            w_if_misaligned_nxt = 1'b0;
          end
        end
        S_FAULT: begin
          if (!stop) begin
            if (!r_fault_done) begin
              w_if_pc_nxt         = r_pc;
              w_if_instr_nxt      = NOP_INSTR;
              w_if_misaligned_nxt = 1'b1;
              w_if_invalid_nxt    = flush;
              w_fault_done_nxt    = 1'b1;
            end else begin
              w_if_invalid_nxt    = 1'b1;
              w_if_misaligned_nxt = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
    // stop+flush still loads the output register, as a bubble
    if (stop && flush) begin
      w_if_invalid_nxt    = 1'b1;
      w_if_misaligned_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: bench-side PC/data model feeds a bundle scoreboard.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } bundle_t;

  logic        clk = 1'b0;
  logic        reset, stop, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_pc, if_instr;
  logic        if_invalid, if_misaligned;
  int          n_chk = 0;
  int          n_fail = 0;
  bundle_t     sb[$];

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0100), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .reset          (reset),
    .stop           (stop),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_invalid     (if_invalid),
    .if_misaligned  (if_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, let posedge happen, return at next negedge
  task automatic cyc(input logic ack, input logic [31:0] rd, input logic st, input logic fl,
                     input logic rv, input logic [31:0] rp);
    bus.imem_ack   = ack;
    bus.imem_rdata = rd;
    stop           = st;
    flush          = fl;
    redirect_valid = rv;
    redirect_pc    = rp;
    @(posedge clk);
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    stop           = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    chk("req", 32'(bus.imem_req), 32'd1);
    chk("addr", bus.imem_addr, a);
    sb.push_back('{pc: a, instr: mem_data(a), mis: 1'b0});
    cyc(1'b1, mem_data(a), 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic expect_bundle(input string tag);
    bundle_t e;
    n_chk++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard expected a bundle", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_pc"}, if_pc, e.pc);
      chk({tag, "_instr"}, if_instr, e.instr);
      chk({tag, "_inv"}, 32'(if_invalid), 32'd0);
      chk({tag, "_mis"}, 32'(if_misaligned), 32'(e.mis));
    end
  endtask

  initial begin
    reset = 1'b1; stop = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_inv", 32'(if_invalid), 32'd1);
    chk("rst_mis", 32'(if_misaligned), 32'd0);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h100);
    reset = 1'b0;
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    // zero-wait streaming from the reset PC
    for (int k = 0; k < 3; k++) begin
      fetch(32'h100 + 32'(4 * k));
      expect_bundle("stream");
    end

    // two wait cycles at 0x200: bubbles while the address holds
    cyc(1'b1, 32'hBAD0_0000, 1'b0, 1'b0, 1'b1, 32'h200);
    for (int k = 0; k < 2; k++) begin
      chk("wait_addr", bus.imem_addr, 32'h200);
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("wait_inv", 32'(if_invalid), 32'd1);
    end
    fetch(32'h200);
    expect_bundle("wait");

    // ack under stop parks the word; IF/ID frozen, no new request
    cyc(1'b1, 32'hBAD0_0001, 1'b0, 1'b0, 1'b1, 32'h300);
    chk("stop_addr", bus.imem_addr, 32'h300);
    cyc(1'b1, 32'h00A0_0093, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      chk("stop_req", 32'(bus.imem_req), 32'd0);
      chk("stop_pc", if_pc, 32'h200);
      cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    end
    sb.push_back('{pc: 32'h300, instr: 32'h00A0_0093, mis: 1'b0});
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    expect_bundle("hold");
    chk("hold_next", bus.imem_addr, 32'h304);

    // redirect with a request outstanding: stale ack must be dropped
    cyc(1'b1, 32'hBAD0_0002, 1'b0, 1'b0, 1'b1, 32'h40C);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h400);
    chk("disc_req", 32'(bus.imem_req), 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("disc_req2", 32'(bus.imem_req), 32'd0);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("disc_instr", if_instr, 32'h00A0_0093);
    chk("disc_inv", 32'(if_invalid), 32'd1);
    fetch(32'h400);
    expect_bundle("disc");

    // misaligned redirect produces a single fault bundle
    cyc(1'b1, 32'hBAD0_0003, 1'b0, 1'b0, 1'b1, 32'h402);
    chk("flt_req", 32'(bus.imem_req), 32'd0);
    sb.push_back('{pc: 32'h402, instr: NOP, mis: 1'b1});
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    expect_bundle("fault");
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("flt_inv2", 32'(if_invalid), 32'd1);
    chk("flt_mis2", 32'(if_misaligned), 32'd0);
    chk("flt_req2", 32'(bus.imem_req), 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h80);
    fetch(32'h80);
    expect_bundle("resume");

    // PC wrap with flush on the loading cycle
    cyc(1'b1, 32'hBAD0_0004, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cyc(1'b1, mem_data(32'hFFFF_FFFC), 1'b0, 1'b1, 1'b0, 32'd0);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_inv", 32'(if_invalid), 32'd1);
    chk("wrap_addr", bus.imem_addr, 32'd0);
    fetch(32'd0);
    expect_bundle("wrap");

    // stop and flush together still bubble the output
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0);
    chk("sf_inv", 32'(if_invalid), 32'd1);
    chk("sf_pc", if_pc, 32'd0);

    // reset with a request in flight: ack in the first cycle after reset is ignored
    reset = 1'b1;
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    cyc(1'b1, 32'hBAD0_0005, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("rr_inv", 32'(if_invalid), 32'd1);
    chk("rr_instr", if_instr, NOP);
    chk("rr_addr", bus.imem_addr, 32'h100);
    chk("rr_req", 32'(bus.imem_req), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage RV32 pipeline. Owns the architectural PC and issues one instruction-memory request at a time.
- Presents {pc, instr, invalid, misaligned} to the IF/ID boundary.
- Consumes the hazard unit's stop_IF and set_invalid_IF, plus the redirect from branch resolution, trap entry and mret.
- Drops stale memory responses after a redirect, so ID never sees wrong-path instructions.

Parameters:
RESET_PC, 32'h00000000, PC loaded on reset
NOP_INSTR, 32'h00000013, instruction driven while invalid (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high
stop  in  1  hold IF/ID outputs and PC (from stop_IF)
flush  in  1  mark the bundle loaded this cycle invalid (from set_invalid_IF)
redirect_valid  in  1  load redirect_pc as next fetch PC (branch taken, trap, mret)
redirect_pc  in  32  redirect target
imem_req  out  1  request valid; held until imem_ack
imem_addr  out  32  word address of the request (= pc)
imem_ack  in  1  response valid; completes the outstanding request
imem_rdata  in  32  instruction word, valid with imem_ack
if_pc  out  32  PC of the presented bundle
if_instr  out  32  presented instruction
if_invalid  out  1  1 = bubble; ID must ignore the bundle
if_misaligned  out  1  fetch-address-misaligned exception attached to the bundle

Behaviour:
- Reset (reset=1 at posedge):
  - pc=RESET_PC, state=FETCH, hold buffer empty.
  - Outputs: imem_req=0, if_pc=0, if_instr=NOP_INSTR, if_invalid=1, if_misaligned=0.
  - Reset mid-request: any ack of the old request arriving in the cycle after reset is ignored.
- Combinational outputs:
  - imem_req=1 only in FETCH and not in the first cycle after reset.
  - imem_addr=pc at all times.
  - Only one request is ever outstanding.
- Priority per cycle: reset > redirect_valid > imem_ack/stop handling.
  - flush forces if_invalid=1 whenever the output register loads, including loads that happen during stop.
- States:
  - FETCH:
    - redirect_valid & imem_ack: drop rdata; pc<=redirect_pc; stay FETCH; if_invalid<=1.
    - redirect_valid & ~imem_ack: pc<=redirect_pc; go to DISCARD; if_invalid<=1.
    - imem_ack & ~stop: if_instr<=rdata; if_pc<=pc; if_invalid<=flush; pc<=pc+4 (mod 2^32, wraps 0xFFFFFFFC->0); stay FETCH.
    - imem_ack & stop: hold buffer<=rdata; outputs unchanged; go to HOLD.
    - no ack & ~stop: if_invalid<=1 (bubble).
    - no ack & stop: outputs unchanged.
  - HOLD:
    - imem_req=0.
    - ~stop: if_instr<=buffer; if_pc<=pc; if_invalid<=flush; pc<=pc+4; go to FETCH.
    - redirect_valid: discard buffer; pc<=redirect_pc; if_invalid<=1; go to FETCH.
  - DISCARD:
    - imem_req=0 while waiting for the stale ack.
    - On imem_ack: drop rdata; go to FETCH. The redirect target is requested the next cycle.
    - Another redirect here: update pc; remain in DISCARD until the ack arrives.
  - FAULT:
    - Entered from any redirect with redirect_pc[1:0]!=0. No request is issued.
    - On the first non-stopped cycle: if_pc<=pc; if_instr<=NOP_INSTR; if_misaligned<=1; if_invalid<=flush.
    - Next non-stopped cycle: if_invalid<=1; if_misaligned<=0.
    - Stays in FAULT until a redirect arrives (trap vector).
    - A misaligned redirect from FETCH with a request outstanding passes through DISCARD first.
- Latency: with ack in the request cycle, the instruction appears on if_* one cycle after imem_req rises. Sustained throughput is 1 instr/cycle.
- stop and flush both high: the output register loads; if_invalid=1.

Test Plan:
- Reset with RESET_PC=0x100, zero-wait memory -> if_pc 0x100, 0x104, 0x108 on consecutive cycles; if_invalid=0 from the 2nd cycle after reset release.
- Memory returns ack 2 cycles after req at 0x200 -> one bubble (if_invalid=1) per wait cycle; imem_addr stays at 0x200 until ack.
- stop=1 for 3 cycles while ack returns 0x00A00093 at 0x300 -> if_* frozen; no new req; after stop falls, if_instr=0x00A00093, if_pc=0x300; the next req is 0x304.
- Redirect to 0x400 while a request to 0x40C is outstanding with no ack -> DISCARD; the stale ack data never reaches if_instr; the next imem_addr is 0x400.
- redirect_pc=0x402 -> no request issued; one bundle with if_pc=0x402, if_misaligned=1, if_invalid=0; then a redirect to 0x80 resumes fetch at 0x80.
- pc=0xFFFFFFFC with ack -> next imem_addr=0x00000000; flush=1 on that cycle -> if_invalid=1 for that bundle.
